// File: rtl/lcd_fetch_sched.sv
// Frame-buffer read scheduler: issues per-line burst reads, buffers returned pixels in a FIFO
// and serves the LCD pixel request. Optional colour-bar generator under LCD_FETCH_COLORBAR_EN.
module lcd_fetch_sched #(
  parameter int unsigned H_DISP      = 800,
  parameter int unsigned V_DISP      = 480,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LINE_STRIDE = 3200,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic [23:0] pix_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_addr,
  output logic [7:0]  cmd_len,
  input  logic        rd_valid,
  input  logic [23:0] rd_data,
  output logic [10:0] line_cnt,
  output logic        underflow,
  output logic        overflow,
  output logic        busy
`ifdef LCD_FETCH_COLORBAR_EN
  ,
  input  logic        test_en
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StFlush, StFetch, StCmd, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  occ_q, outst_q, outst_d, free;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [23:0]    mem [FIFO_DEPTH];
  logic [15:0]    remaining_q, remaining_d;
  logic [31:0]    cmd_addr_q, cmd_addr_d, line_addr_q, line_addr_d;
  logic [10:0]    line_cnt_q, line_cnt_d;
  logic           fs_pend_q, fs_pend_d;
  logic [8:0]     len;
  logic           hs, init, push, pop, uf_set, ov_set, flushing;
  logic [23:0]    pix_d;

`ifndef LCD_FETCH_COLORBAR_EN
  logic test_en;
  assign test_en = 1'b0;
`endif

  assign len       = (remaining_q >= 16'(BURST_LEN)) ? 9'(BURST_LEN) : remaining_q[8:0];
  assign free      = CW'(FIFO_DEPTH) - occ_q - outst_q;
  assign cmd_valid = (state_q == StCmd);
  assign hs        = cmd_valid && cmd_ready;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_valid ? 8'(len - 9'd1) : 8'd0;
  assign line_cnt  = line_cnt_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign outst_d   = outst_q + (hs ? CW'(len) : '0) - CW'(rd_valid);

  always_comb begin
    state_d     = state_q;
    init        = 1'b0;
    fs_pend_d   = fs_pend_q;
    remaining_d = remaining_q;
    cmd_addr_d  = cmd_addr_q;
    line_addr_d = line_addr_q;
    line_cnt_d  = line_cnt_q;
    if (hs) begin
      remaining_d = remaining_q - 16'(len);
      cmd_addr_d  = cmd_addr_q + {21'd0, len, 2'b00};
      if (remaining_d == 16'd0) begin
        line_cnt_d  = line_cnt_q + 11'd1;
        line_addr_d = line_addr_q + LINE_STRIDE;
        cmd_addr_d  = line_addr_d;
        remaining_d = 16'(H_DISP);
      end
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (frame_start) init = 1'b1;
      end
      StFlush: begin
        if (frame_start) init = 1'b1;
        else if (outst_d == '0) state_d = StFetch;
      end
      StFetch: begin
        if (frame_start) init = 1'b1;
        else if (!test_en && (32'(free) >= 32'(len))) state_d = StCmd;
      end
      StCmd: begin
        // A frame start seen mid-command waits for the handshake so the burst stays accounted.
        if (hs) begin
          if (fs_pend_q || frame_start) init = 1'b1;
          else state_d = (line_cnt_d == 11'(V_DISP)) ? StDone : StFetch;
        end else begin
          fs_pend_d = fs_pend_q | frame_start;
        end
      end
      default: state_d = StIdle;
    endcase
    if (init) begin
      state_d     = StFlush;
      fs_pend_d   = 1'b0;
      line_cnt_d  = '0;
      line_addr_d = BASE_ADDR;
      cmd_addr_d  = BASE_ADDR;
      remaining_d = 16'(H_DISP);
    end
  end

  assign flushing = (state_q == StFlush);
  assign push     = rd_valid && !flushing && !init && (occ_q != CW'(FIFO_DEPTH));
  assign ov_set   = rd_valid && !flushing && !init && (occ_q == CW'(FIFO_DEPTH));
  assign pop      = pix_req && !test_en && !flushing && (occ_q != '0);
  assign uf_set   = pix_req && !test_en && (flushing || (occ_q == '0));

`ifdef LCD_FETCH_COLORBAR_EN
  logic [15:0] x_q;
  logic [2:0]  bar;
  logic [23:0] bar_rgb;

  assign bar = 3'((32'(x_q) * 32'd8) / 32'(H_DISP));

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) x_q <= '0;
    else if (test_en && pix_req) x_q <= (x_q == 16'(H_DISP - 1)) ? '0 : x_q + 16'd1;
  end
`endif

  always_comb begin
    pix_d = 24'h000000;
`ifdef LCD_FETCH_COLORBAR_EN
    if (test_en) pix_d = pix_req ? bar_rgb : 24'h000000;
    else if (pop) pix_d = mem[rd_ptr_q];
`else
    if (pop) pix_d = mem[rd_ptr_q];
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      occ_q       <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      cmd_addr_q  <= '0;
      line_addr_q <= '0;
      line_cnt_q  <= '0;
      fs_pend_q   <= 1'b0;
      pix_data    <= '0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      outst_q     <= outst_d;
      remaining_q <= remaining_d;
      cmd_addr_q  <= cmd_addr_d;
      line_addr_q <= line_addr_d;
      line_cnt_q  <= line_cnt_d;
      fs_pend_q   <= fs_pend_d;
      pix_data    <= pix_d;
      if (init) begin
        occ_q     <= '0;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        underflow <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        occ_q     <= occ_q + CW'(push) - CW'(pop);
        wr_ptr_q  <= wr_ptr_q + AW'(push);
        rd_ptr_q  <= rd_ptr_q + AW'(pop);
        underflow <= underflow | uf_set;
        overflow  <= overflow | ov_set;
      end
    end
  end

endmodule
